// File: rtl/cam_pkg.sv
// Shared definitions for the camera pixel capture block: FSM states,
// standard resolutions and the frame counter width.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE,
    VBLANK,
    LWAIT,
    ACTIVE
  } cam_state_t;

  localparam int VGA_H_ACTIVE  = 640;
  localparam int VGA_V_ACTIVE  = 480;
  localparam int QVGA_H_ACTIVE = 320;
  localparam int QVGA_V_ACTIVE = 240;

  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/cam_byte_assembler.sv
// Packs BPP consecutive camera bytes into one pixel word; 'done' flags the
// byte that completes a pixel, with 'word' already holding the full pixel.
module cam_byte_assembler #(
  parameter int DIN_W     = 8,
  parameter int BPP       = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                   pclk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clr,
  input  logic [DIN_W-1:0]       din,
  output logic [BPP*DIN_W-1:0]   word,
  output logic                   done,
  output logic [1:0]             cnt
);

  localparam int OW = BPP * DIN_W;

  logic [OW-1:0] sr;
  logic [OW-1:0] shifted;

  // MSB-first shifts bytes up from the bottom; LSB-first shifts them down
  // from the top, so after BPP bytes the first byte sits at the chosen end.
  always_comb begin
    if (MSB_FIRST != 0) begin
      shifted = (sr << DIN_W) | OW'(din);
    end else begin
      shifted = (sr >> DIN_W) | (OW'(din) << (OW - DIN_W));
    end
    word = shifted;
    done = en && (cnt == 2'(BPP - 1));
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (en) begin
      if (done) begin
        sr  <= '0;
        cnt <= '0;
      end else begin
        sr  <= shifted;
        cnt <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/cam_pixel_capture.sv
// Camera DVP capture: registers vsync/href/data, tracks frame/line state and
// emits assembled pixels with position, framing markers and error pulses.
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int DIN_W     = 8,
  parameter int BPP       = 2,
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int MSB_FIRST = 1
) (
  input  logic                            pclk,
  input  logic                            reset,
  input  logic [DIN_W-1:0]                din,
  input  logic                            vsync,
  input  logic                            href,
  output logic [BPP*DIN_W-1:0]            dout,
  output logic                            dout_valid,
  output logic                            sof,
  output logic                            eol,
  output logic                            eof,
  output logic [$clog2(H_ACTIVE+1)-1:0]   x,
  output logic [$clog2(V_ACTIVE+1)-1:0]   y,
  output logic                            line_err,
  output logic                            frame_err,
  output logic [FRAME_CNT_W-1:0]          frame_cnt
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam int PW = $clog2(H_ACTIVE + 2);

  localparam logic [PW-1:0] PIX_FULL  = PW'(H_ACTIVE);
  localparam logic [PW-1:0] PIX_LAST  = PW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] X_SAT     = XW'(H_ACTIVE);
  localparam logic [YW-1:0] LINE_FULL = YW'(V_ACTIVE);
  localparam logic [YW-1:0] LINE_LAST = YW'(V_ACTIVE - 1);

  cam_state_t          state;
  logic [DIN_W-1:0]    din_r;
  logic                href_r;
  logic                vsync_r;
  logic [PW-1:0]       pix_cnt;
  logic [YW-1:0]       line_cnt;

  logic                accept;
  logic                line_end;
  logic                frame_end;
  logic                pix_done;
  logic [1:0]          byte_cnt;
  logic [BPP*DIN_W-1:0] word;

  always_comb begin
    accept    = href_r && !vsync_r && (state == LWAIT || state == ACTIVE);
    line_end  = (state == ACTIVE) && (vsync_r || !href_r);
    frame_end = vsync_r && (state == LWAIT || state == ACTIVE);
  end

  cam_byte_assembler #(
    .DIN_W     (DIN_W),
    .BPP       (BPP),
    .MSB_FIRST (MSB_FIRST)
  ) u_asm (
    .pclk  (pclk),
    .reset (reset),
    .en    (accept),
    .clr   (!accept),
    .din   (din_r),
    .word  (word),
    .done  (pix_done),
    .cnt   (byte_cnt)
  );

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      din_r      <= '0;
      href_r     <= 1'b0;
      vsync_r    <= 1'b0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      eof        <= 1'b0;
      x          <= '0;
      y          <= '0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      din_r      <= din;
      href_r     <= href;
      vsync_r    <= vsync;
      dout_valid <= 1'b0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      eof        <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;

      unique case (state)
        IDLE:    if (vsync_r) state <= VBLANK;
        VBLANK:  if (!vsync_r) state <= LWAIT;
        LWAIT:   if (vsync_r) state <= VBLANK;
                 else if (href_r) state <= ACTIVE;
        ACTIVE:  if (vsync_r) state <= VBLANK;
                 else if (!href_r) state <= LWAIT;
        default: state <= IDLE;
      endcase

      // pix_cnt runs one past H_ACTIVE so an over-long line is still
      // distinguishable from an exact one when the line closes.
      if (pix_done) begin
        dout       <= word;
        dout_valid <= 1'b1;
        x          <= (pix_cnt >= PIX_FULL) ? X_SAT : XW'(pix_cnt);
        y          <= line_cnt;
        sof        <= (pix_cnt == '0) && (line_cnt == '0);
        eol        <= (pix_cnt == PIX_LAST);
        eof        <= (pix_cnt == PIX_LAST) && (line_cnt == LINE_LAST);
        if (pix_cnt <= PIX_FULL) pix_cnt <= pix_cnt + 1'b1;
      end

      if (line_end) begin
        line_err <= (byte_cnt != 2'd0) || (pix_cnt != PIX_FULL);
        pix_cnt  <= '0;
        if (!vsync_r && line_cnt != LINE_FULL) line_cnt <= line_cnt + 1'b1;
      end

      if (frame_end) begin
        frame_err <= (line_cnt != LINE_FULL);
        if (line_cnt == LINE_FULL) frame_cnt <= frame_cnt + 1'b1;
        line_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed bench for cam_pixel_capture (BPP=2, 4x2 frame); a second
// instance with LSB-first byte order shares the same stimulus.
module tb_cam_pixel_capture;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  din = '0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;

  logic [15:0] dout, dout_b;
  logic        dout_valid, sof, eol, eof, line_err, frame_err;
  logic        dout_valid_b, sof_b, eol_b, eof_b, line_err_b, frame_err_b;
  logic [2:0]  x, x_b;
  logic [1:0]  y, y_b;
  logic [15:0] frame_cnt, frame_cnt_b;

  cam_pixel_capture #(
    .DIN_W(8), .BPP(2), .H_ACTIVE(4), .V_ACTIVE(2), .MSB_FIRST(1)
  ) dut (
    .pclk(pclk), .reset(reset), .din(din), .vsync(vsync), .href(href),
    .dout(dout), .dout_valid(dout_valid), .sof(sof), .eol(eol), .eof(eof),
    .x(x), .y(y), .line_err(line_err), .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );

  cam_pixel_capture #(
    .DIN_W(8), .BPP(2), .H_ACTIVE(4), .V_ACTIVE(2), .MSB_FIRST(0)
  ) dut_lsb (
    .pclk(pclk), .reset(reset), .din(din), .vsync(vsync), .href(href),
    .dout(dout_b), .dout_valid(dout_valid_b), .sof(sof_b), .eol(eol_b),
    .eof(eof_b), .x(x_b), .y(y_b), .line_err(line_err_b),
    .frame_err(frame_err_b), .frame_cnt(frame_cnt_b)
  );

  always #5 pclk = ~pclk;

  int unsigned cyc = 0;
  int unsigned le_cnt = 0;
  int unsigned fe_cnt = 0;
  int unsigned le_cyc = 0;
  logic [15:0] q_dout[$];
  logic [2:0]  q_x[$];
  logic [1:0]  q_y[$];
  logic [2:0]  q_flags[$];
  int unsigned q_cyc[$];
  logic [15:0] q_dout_b[$];

  always @(posedge pclk) begin
    #1;
    cyc++;
    if (dout_valid) begin
      q_dout.push_back(dout);
      q_x.push_back(x);
      q_y.push_back(y);
      q_flags.push_back({sof, eol, eof});
      q_cyc.push_back(cyc);
    end
    if (dout_valid_b) q_dout_b.push_back(dout_b);
    if (line_err) begin
      le_cnt++;
      le_cyc = cyc;
    end
    if (frame_err) fe_cnt++;
  end

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [7:0]  line_buf[16];
  int unsigned t_byte1 = 0;
  int unsigned t_fall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_std();
    for (int unsigned i = 0; i < 8; i++) line_buf[i] = 8'((i + 1) * 17);
  endtask

  task automatic idle(input int unsigned n);
    @(negedge pclk);
    din = '0; href = 1'b0; vsync = 1'b0;
    repeat (n) @(negedge pclk);
  endtask

  task automatic vsync_pulse();
    @(negedge pclk);
    din = '0; href = 1'b0; vsync = 1'b1;
    repeat (3) @(negedge pclk);
    vsync = 1'b0;
    repeat (3) @(negedge pclk);
  endtask

  task automatic send_line(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge pclk);
      din = line_buf[i]; href = 1'b1; vsync = 1'b0;
      if (i == 1) t_byte1 = cyc;
    end
    @(negedge pclk);
    din = '0; href = 1'b0;
    t_fall = cyc;
    repeat (4) @(negedge pclk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout"}, dout, 16'h0);
    chk({tag, "_valid"}, dout_valid, 1'b0);
    chk({tag, "_flags"}, {sof, eol, eof}, 3'b000);
    chk({tag, "_errs"}, {line_err, frame_err}, 2'b00);
    chk({tag, "_xy"}, {x, y}, 5'd0);
    chk({tag, "_fcnt"}, frame_cnt, 16'h0);
  endtask

  // Two full lines of bytes 0x11..0x88 give pixels 1122,3344,5566,7788 per line.
  task automatic check_frame(input int unsigned base, input logic [15:0] exp_fc);
    chk("frame_pix_count", q_dout.size() - base, 8);
    if (q_dout.size() >= base + 8) begin
      for (int unsigned p = 0; p < 8; p++) begin
        chk("frame_dout", q_dout[base+p], {8'((2*(p%4)+1)*17), 8'((2*(p%4)+2)*17)});
        chk("frame_x", q_x[base+p], 3'(p % 4));
        chk("frame_y", q_y[base+p], 2'(p / 4));
        chk("frame_sof_eol_eof", q_flags[base+p],
            {p == 0, (p % 4) == 3, p == 7});
      end
    end
    chk("frame_cnt", frame_cnt, exp_fc);
  endtask

  int unsigned base, bbase, le0;

  initial begin
    repeat (3) @(negedge pclk);
    #1 chk_reset_outputs("rst_init");
    @(negedge pclk) reset = 1'b0;

    // Data before the first vsync is ignored.
    fill_std();
    send_line(8);
    idle(2);
    chk("pre_vsync_valid", q_dout.size(), 0);
    chk("pre_vsync_fcnt", frame_cnt, 16'h0);

    // Nominal frame.
    vsync_pulse();
    base = q_dout.size();
    bbase = q_dout_b.size();
    send_line(8);
    if (q_cyc.size() > base) chk("first_pixel_latency", q_cyc[base], t_byte1 + 2);
    else chk("first_pixel_present", q_cyc.size(), base + 1);
    send_line(8);
    vsync_pulse();
    check_frame(base, 16'd1);
    chk("lsb_nominal_first", (q_dout_b.size() > bbase) ? q_dout_b[bbase] : 16'hxxxx, 16'h2211);
    chk("nominal_line_err", le_cnt, 0);
    chk("nominal_frame_err", fe_cnt, 0);

    // Short line of 7 bytes: 3 pixels, partial pixel dropped, line_err once.
    line_buf[0] = 8'hAB; line_buf[1] = 8'hCD; line_buf[2] = 8'h01;
    line_buf[3] = 8'h02; line_buf[4] = 8'h03; line_buf[5] = 8'h04;
    line_buf[6] = 8'h05;
    base = q_dout.size();
    bbase = q_dout_b.size();
    send_line(7);
    chk("short_pix_count", q_dout.size() - base, 3);
    if (q_dout.size() >= base + 3) begin
      chk("short_dout0", q_dout[base], 16'hABCD);
      chk("short_dout1", q_dout[base+1], 16'h0102);
      chk("short_dout2", q_dout[base+2], 16'h0304);
    end
    chk("lsb_order", (q_dout_b.size() > bbase) ? q_dout_b[bbase] : 16'hxxxx, 16'hCDAB);
    chk("short_line_err_cnt", le_cnt, 1);
    // line_err is one cycle after the registered href falls.
    chk("short_line_err_time", le_cyc, t_fall + 2);

    fill_std();
    base = q_dout.size();
    send_line(8);
    chk("next_line_pix_count", q_dout.size() - base, 4);
    if (q_dout.size() > base) begin
      chk("next_line_x0", q_x[base], 3'd0);
      chk("next_line_dout0", q_dout[base], 16'h1122);
    end
    chk("next_line_no_err", le_cnt, 1);
    vsync_pulse();
    chk("frame2_cnt", frame_cnt, 16'd2);
    chk("frame2_no_ferr", fe_cnt, 0);

    // Frame with a single line: frame_err once, frame_cnt unchanged.
    send_line(8);
    vsync_pulse();
    chk("short_frame_ferr", fe_cnt, 1);
    chk("short_frame_fcnt", frame_cnt, 16'd2);
    chk("short_frame_line_err", le_cnt, 1);

    // Reset after the third byte of a line, then a clean frame.
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge pclk);
      din = line_buf[i]; href = 1'b1; vsync = 1'b0;
    end
    le0 = le_cnt;
    @(negedge pclk);
    reset = 1'b1; din = line_buf[3];
    #1 chk_reset_outputs("rst_async");
    repeat (2) @(negedge pclk);
    #1 chk_reset_outputs("rst_hold");
    @(negedge pclk);
    reset = 1'b0; href = 1'b0; din = '0;
    idle(3);
    chk("rst_no_line_err", le_cnt, le0);
    vsync_pulse();
    base = q_dout.size();
    send_line(8);
    send_line(8);
    vsync_pulse();
    check_frame(base, 16'd1);
    chk("rst_frame_line_err", le_cnt, le0);
    chk("rst_frame_ferr", fe_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
